// File: rtl/lector_banco_pkg.sv
// Shared definitions for the counter-bank read scanner.
// The default widths are also used where the bank itself is instantiated.
package lector_banco_pkg;

    localparam int BIT_ADDR_DEF = 4;
    localparam int BIT_DATO_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } estado_t;

endpackage

// File: rtl/lector_banco_acumulador_max.sv
// Running sum and arg-max over the values fed during one scan.
// A strict compare keeps the lowest index when several entries tie.
module acumulador_max
    import lector_banco_pkg::*;
#(
    parameter int BIT_ADDR = BIT_ADDR_DEF,
    parameter int BIT_DATO = BIT_DATO_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         enable,
    input  logic [BIT_DATO-1:0]          value,
    input  logic [BIT_ADDR-1:0]          index,
    output logic [BIT_ADDR+BIT_DATO-1:0] acc_sum,
    output logic [BIT_DATO-1:0]          acc_max,
    output logic [BIT_ADDR-1:0]          acc_idx
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc_sum <= '0;
            acc_max <= '0;
            acc_idx <= '0;
        end else if (enable) begin
            acc_sum <= acc_sum + (BIT_ADDR+BIT_DATO)'(value);
            if (value > acc_max) begin
                acc_max <= value;
                acc_idx <= index;
            end
        end
    end

endmodule

// File: rtl/lector_banco.sv
// Walks the counter bank once per start pulse, streaming (addr, count)
// pairs over valid/ready and publishing the total and arg-max at the end.
module lector_banco
    import lector_banco_pkg::*;
#(
    parameter int BIT_ADDR = BIT_ADDR_DEF,
    parameter int BIT_DATO = BIT_DATO_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic [BIT_ADDR-1:0]          addrR,
    input  logic [BIT_DATO-1:0]          datInR,
    output logic                         busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BIT_ADDR-1:0]          out_addr,
    output logic [BIT_DATO-1:0]          out_dato,
    output logic                         done,
    output logic [BIT_ADDR+BIT_DATO-1:0] sum,
    output logic [BIT_ADDR-1:0]          max_addr,
    output logic [BIT_DATO-1:0]          max_dato
);

    localparam logic [BIT_ADDR-1:0] LAST = '1;

    estado_t               state;
    logic [BIT_ADDR-1:0]   idx;
    logic                  acc_clear;
    logic                  acc_en;
    logic [BIT_ADDR+BIT_DATO-1:0] acc_sum;
    logic [BIT_DATO-1:0]   acc_max;
    logic [BIT_ADDR-1:0]   acc_idx;

    assign acc_clear = (state == ST_IDLE) && start;
    assign acc_en    = (state == ST_LOAD);

    acumulador_max #(
        .BIT_ADDR (BIT_ADDR),
        .BIT_DATO (BIT_DATO)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .clear   (acc_clear),
        .enable  (acc_en),
        .value   (datInR),
        .index   (idx),
        .acc_sum (acc_sum),
        .acc_max (acc_max),
        .acc_idx (acc_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            addrR     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_dato  <= '0;
            done      <= 1'b0;
            sum       <= '0;
            max_addr  <= '0;
            max_dato  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    addrR <= '0;
                    if (start) begin
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    out_dato  <= datInR;
                    out_addr  <= idx;
                    out_valid <= 1'b1;
                    state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (idx == LAST) begin
                            // accumulators already hold the last entry
                            done     <= 1'b1;
                            sum      <= acc_sum;
                            max_addr <= acc_idx;
                            max_dato <= acc_max;
                            addrR    <= '0;
                            state    <= ST_DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            addrR <= idx + 1'b1;
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lector_banco.sv
// Directed + randomized bench for lector_banco with a behavioural bank model.
module tb_lector_banco;

    localparam int BA = 4;
    localparam int BD = 3;
    localparam int NREG = 1 << BA;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [BA-1:0] addrR;
    logic [BD-1:0] datInR;
    logic          busy;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BA-1:0] out_addr;
    logic [BD-1:0] out_dato;
    logic          done;
    logic [BA+BD-1:0] sum;
    logic [BA-1:0] max_addr;
    logic [BD-1:0] max_dato;

    logic [BD-1:0] bank [NREG];

    int vecs = 0;
    int errs = 0;
    int pub_sum = 0;
    int pub_maxa = 0;
    int pub_maxd = 0;

    assign datInR = bank[addrR];

    always #5 clk = ~clk;

    lector_banco #(.BIT_ADDR(BA), .BIT_DATO(BD)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .addrR     (addrR),
        .datInR    (datInR),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_dato  (out_dato),
        .done      (done),
        .sum       (sum),
        .max_addr  (max_addr),
        .max_dato  (max_dato)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " addrR"}, 32'(addrR), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " out_valid"}, 32'(out_valid), 0);
        chk({tag, " out_addr"}, 32'(out_addr), 0);
        chk({tag, " out_dato"}, 32'(out_dato), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " sum"}, 32'(sum), 0);
        chk({tag, " max_addr"}, 32'(max_addr), 0);
        chk({tag, " max_dato"}, 32'(max_dato), 0);
    endtask

    // rnd: random out_ready; poke: extra start pulse while busy
    task automatic run_scan(input bit rnd, input bit poke);
        int esum, emax, emaxa, got, k;
        bit pv, pr, finished;
        logic [BA-1:0] pa;
        logic [BD-1:0] pd;
        esum = 0; emax = 0; emaxa = 0;
        for (int i = 0; i < NREG; i++) begin
            esum += int'(bank[i]);
            if (int'(bank[i]) > emax) begin
                emax = int'(bank[i]);
                emaxa = i;
            end
        end
        @(negedge clk);
        start = 1'b1;
        got = 0; pv = 0; pr = 0; pa = '0; pd = '0; finished = 0;
        for (k = 0; k < 2000 && !finished; k++) begin
            @(negedge clk);
            start = (poke && k == 6) ? 1'b1 : 1'b0;
            if (pv && !pr) begin
                chk("stall valid", 32'(out_valid), 1);
                chk("stall addr", 32'(out_addr), 32'(pa));
                chk("stall dato", 32'(out_dato), 32'(pd));
            end
            if (!rnd) begin
                chk("tp valid", 32'(out_valid),
                    32'((k % 2 == 1) && k < 2 * NREG));
                chk("tp done", 32'(done), 32'(k == 2 * NREG));
                chk("tp busy", 32'(busy), 1);
            end
            if (done) begin
                finished = 1;
                chk("pairs", got, NREG);
                chk("sum", 32'(sum), esum);
                chk("max_addr", 32'(max_addr), emaxa);
                chk("max_dato", 32'(max_dato), emax);
                pub_sum = esum; pub_maxa = emaxa; pub_maxd = emax;
            end else begin
                chk("sum held", 32'(sum), pub_sum);
                chk("max held", 32'(max_dato), pub_maxd);
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                chk("pair addr", 32'(out_addr), got);
                chk("pair dato", 32'(out_dato), 32'(bank[got % NREG]));
                got++;
            end
            pv = out_valid; pr = out_ready; pa = out_addr; pd = out_dato;
        end
        if (!finished) chk("scan timeout", 0, 1);
        @(negedge clk);
        chk("post busy", 32'(busy), 0);
        chk("post done", 32'(done), 0);
        chk("post valid", 32'(out_valid), 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < NREG; i++) bank[i] = '0;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b0;

        run_scan(0, 0);

        for (int i = 0; i < NREG; i++) bank[i] = BD'(i % 8);
        run_scan(0, 0);

        for (int i = 0; i < NREG; i++) bank[i] = 3'd1;
        bank[3] = 3'd5;
        bank[9] = 3'd5;
        run_scan(0, 0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NREG; i++) bank[i] = BD'($urandom);
            run_scan(1, r[0]);
        end

        for (int i = 0; i < NREG; i++) bank[i] = BD'($urandom);
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end while (!(out_valid && out_addr == 4'd6) && n < 200);
        chk("reach idx6", 32'(out_valid && out_addr == 4'd6), 1);
        rst = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        chk_zero_outputs("midrst");
        rst = 1'b0;
        pub_sum = 0; pub_maxa = 0; pub_maxd = 0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst no done", 32'(done), 0);
            chk("midrst idle", 32'(busy), 0);
        end
        run_scan(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
